ulaplus_port_ctrl: RTL
======================

# ulaplus_port_ctrl

I/O-port front end for the 64-entry ULAplus palette RAM. It decodes Z80 I/O cycles on ports 0xBF3B (register select) and 0xFF3B (data). It turns each data-port write into exactly one single-cycle palette load or mode update, and returns palette or mode contents on data-port reads. It sits directly upstream of the palette LUT: it drives the LUT's load/address/data port and consumes that port's registered read output.

## Interface
- `FULL_DECODE`, default 1: 1 = decode all 16 address bits. 0 = decode only a[15]=1, a[7:0]=0x3B, with a[14] selecting the port.
- `ENABLE_AT_RESET`, default 0: reset value of the ULAplus enable bit.

Ports:
- `clk`  in  1  system clock; Z80 bus signals are already synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  16  Z80 address bus.
- `iorq_n`  in  1  Z80 IORQ, active low.
- `rd_n`  in  1  Z80 RD, active low.
- `wr_n`  in  1  Z80 WR, active low.
- `din`  in  8  CPU write data.
- `dout`  out  8  CPU read data.
- `oe`  out  1  high while this block drives the CPU data bus.
- `lut_load`  out  1  one-cycle write strobe to the palette LUT.
- `lut_addr`  out  6  palette index for the LUT load/readback port.
- `lut_din`  out  8  palette write data (GGGRRRBB).
- `lut_q`  in  8  LUT readback data; registered, valid 1 cycle after `lut_addr` while `lut_load`=0.
- `ulaplus_en`  out  1  ULAplus mode enable, consumed by the video stage.

## Operation
- **Port decode**
  - `sel_reg` = (`a`==0xBF3B).
  - `sel_dat` = (`a`==0xFF3B).
  - With `FULL_DECODE`=0, a[13:8] is ignored.
- **Register select `regsel[7:0]`**
  - Written by any write to `sel_reg`.
  - Group = regsel[7:6]: 00 = palette, 01 = mode, 10/11 = reserved.
  - Index = regsel[5:0].
- **Data-port write**
  - Palette group: `lut_load`=1 for one cycle, `lut_addr`=index, `lut_din`=latched `din`.
  - Mode group: `ulaplus_en` <= din[0].
  - Reserved group: no effect.
- **Data-port read** (iorq_n=0, rd_n=0, `sel_dat`)
  - `oe`=1 combinationally.
  - Palette group: `dout`=`lut_q`.
  - Mode group: `dout`={7'b0,`ulaplus_en`}.
  - Reserved group: `dout`=0xFF.
- **Register-port reads:** not decoded; `oe` stays 0.
- **`lut_addr`:** always equals regsel[5:0], so `lut_q` continuously tracks the selected entry.
- **Write FSM**, driven by `wstb` = !iorq_n & !wr_n & (`sel_reg`|`sel_dat`):
  - IDLE: on `wstb`, latch `a[14]` and `din`, go to ACT.
  - ACT (one cycle): perform the action (register load / `lut_load` / mode update), go to HOLD.
  - HOLD: stay while `wstb`=1; return to IDLE when `wstb`=0.
  - Result: exactly one action per I/O write, however long the strobe.
- **Reset values:** FSM=IDLE, `regsel`=0x00, `ulaplus_en`=`ENABLE_AT_RESET`, `lut_load`=0, `lut_din`=0, `lut_addr`=0.
  - `oe`=0 whenever no read is in progress, including during reset.
  - `dout` follows its combinational rule.
- **Reset asserted mid-cycle:** FSM returns to IDLE and `lut_load` drops immediately; a partially seen write is discarded.

## Timing
- Write latency: strobe sampled at edge N → action registered at edge N+1. `lut_load` is high for cycle N+1→N+2 only.
- The LUT holds `lut_q` during the load cycle. Readback of the written value is valid 2 cycles after `lut_load` falls.
- Register-select write followed by a read: `lut_q` is valid 2 cycles after `regsel` updates. Z80 I/O cycles are at least 4 CPU clocks, so no wait states are needed.
- A read strobe overlapping an active write strobe is not possible on the Z80 bus; if it occurs, the write takes precedence and `oe` is still driven.
- A new `wstb` arriving in ACT or HOLD is ignored until IDLE is re-entered.

## Structure
- Shared package holds:
  - port constants `ULAPLUS_REG_PORT`=0xBF3B and `ULAPLUS_DAT_PORT`=0xFF3B;
  - group codes `GRP_PALETTE`=2'b00 and `GRP_MODE`=2'b01;
  - FSM state encoding.
- One natural sub-module, `io_strobe_edge`, implements the IDLE/ACT/HOLD one-shot. Everything else is flat.

## Test plan
- **Reset:** assert `rst_n`=0 mid-write → FSM IDLE, `lut_load`=0, `ulaplus_en`=`ENABLE_AT_RESET`, `regsel`=0.
- **Palette write:** OUT 0xBF3B,0x05 then OUT 0xFF3B,0xE3 with a 6-clock strobe → exactly one `lut_load` pulse with `lut_addr`=5 and `lut_din`=0xE3; IN 0xFF3B then returns 0xE3 with `oe`=1.
- **Mode:** OUT 0xBF3B,0x40; OUT 0xFF3B,0x01 → `ulaplus_en`=1 and no `lut_load`; IN 0xFF3B → 0x01. Writing 0x00 clears it.
- **Reserved group:** OUT 0xBF3B,0x80; OUT 0xFF3B,0x55 → no load, no mode change; IN 0xFF3B → 0xFF.
- **Decode:** OUT 0xBE3B,0x12 and 0x7F3B with `FULL_DECODE`=1 → ignored. With `FULL_DECODE`=0, OUT 0xBE3B → accepted as a register-port write.
- **Index wrap / back-to-back:** write index 63 then index 0 in consecutive I/O cycles → two separate loads, to addresses 63 and 0, with no merged or missed pulse.

Source files
------------

// File: rtl/ulaplus_port_ctrl_pkg.sv
// Shared constants and the write-FSM state encoding for the ULAplus
// palette/mode I/O front end.
package ulaplus_port_ctrl_pkg;

    localparam logic [15:0] ULAPLUS_REG_PORT = 16'hBF3B;
    localparam logic [15:0] ULAPLUS_DAT_PORT = 16'hFF3B;
    localparam logic [7:0]  ULAPLUS_PORT_LO  = 8'h3B;

    localparam logic [1:0] GRP_PALETTE = 2'b00;
    localparam logic [1:0] GRP_MODE    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_HOLD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ulaplus_port_ctrl_io_strobe_edge.sv
// One-shot for Z80 I/O write strobes: one ACT cycle per strobe, however long
// the strobe is held.
//   state | meaning
//   IDLE  | waiting for a write strobe; capture asserted on its first cycle
//   ACT   | single cycle in which the write action is performed
//   HOLD  | strobe still asserted; wait for it to drop
module io_strobe_edge
    import ulaplus_port_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      strobe_i,
    output logic      capture_o,
    output logic      fire_o,
    output wr_state_t state_o
);

    wr_state_t state_q;
    logic      fire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fire_q  <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (strobe_i) begin
                        state_q <= ST_ACT;
                        fire_q  <= 1'b1;
                    end
                end
                ST_ACT:  state_q <= ST_HOLD;
                ST_HOLD: begin
                    if (!strobe_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign capture_o = (state_q == ST_IDLE) && strobe_i;
    assign fire_o    = fire_q;
    assign state_o   = state_q;

endmodule

// File: rtl/ulaplus_port_ctrl.sv
// ULAplus I/O port front end: decodes the register-select and data ports and
// drives the palette LUT load/readback port and the mode enable.
module ulaplus_port_ctrl
    import ulaplus_port_ctrl_pkg::*;
#(
    parameter bit FULL_DECODE     = 1'b1,
    parameter bit ENABLE_AT_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic        lut_load,
    output logic [5:0]  lut_addr,
    output logic [7:0]  lut_din,
    input  logic [7:0]  lut_q,
    output logic        ulaplus_en
);

    logic       sel_reg, sel_dat, port_base;
    logic       wstb, capture, fire;
    wr_state_t  wr_state;

    logic       port_q;
    logic [7:0] wdat_q;
    logic [7:0] regsel_q, regsel_d;
    logic       en_q, en_d;
    logic       lut_load_q, lut_load_d;
    logic [7:0] lut_din_q, lut_din_d;

    always_comb begin
        port_base = a[15] && (a[7:0] == ULAPLUS_PORT_LO);
        if (FULL_DECODE) begin
            sel_reg = (a == ULAPLUS_REG_PORT);
            sel_dat = (a == ULAPLUS_DAT_PORT);
        end else begin
            sel_reg = port_base && !a[14];
            sel_dat = port_base && a[14];
        end
    end

    assign wstb = !iorq_n && !wr_n && (sel_reg || sel_dat);

    io_strobe_edge u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_i  (wstb),
        .capture_o (capture),
        .fire_o    (fire),
        .state_o   (wr_state)
    );

    // port_q: 1 = data port, 0 = register-select port (a[14] at strobe start)
    always_comb begin
        regsel_d   = regsel_q;
        en_d       = en_q;
        lut_load_d = 1'b0;
        lut_din_d  = lut_din_q;
        if (fire) begin
            if (!port_q) begin
                regsel_d = wdat_q;
            end else begin
                unique case (regsel_q[7:6])
                    GRP_PALETTE: begin
                        lut_load_d = 1'b1;
                        lut_din_d  = wdat_q;
                    end
                    GRP_MODE: en_d = wdat_q[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q     <= 1'b0;
            wdat_q     <= 8'h00;
            regsel_q   <= 8'h00;
            en_q       <= ENABLE_AT_RESET;
            lut_load_q <= 1'b0;
            lut_din_q  <= 8'h00;
        end else begin
            if (capture) begin
                port_q <= a[14];
                wdat_q <= din;
            end
            regsel_q   <= regsel_d;
            en_q       <= en_d;
            lut_load_q <= lut_load_d;
            lut_din_q  <= lut_din_d;
        end
    end

    always_comb begin
        unique case (regsel_q[7:6])
            GRP_PALETTE: dout = lut_q;
            GRP_MODE:    dout = {7'b0, en_q};
            default:     dout = 8'hFF;
        endcase
    end

    assign oe         = !iorq_n && !rd_n && sel_dat;
    assign lut_load   = lut_load_q;
    assign lut_addr   = regsel_q[5:0];
    assign lut_din    = lut_din_q;
    assign ulaplus_en = en_q;

endmodule
